// File: rtl/transmitter.sv
// transmitter: serialises parallel words onto a one-bit-per-clock line.
// Frame on the line: start bit (1), DATA_WIDTH data bits LSB first, stop bit (1).
// The line idles low. GAP_CYCLES forces idle-low cycles after every stop bit.
// Optional feature: define TRANSMITTER_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
module transmitter #(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

`ifdef TRANSMITTER_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_GAP    = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4,
    S_GAP   = 3'd5
  } state_t;
`endif

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CW-1:0]         bit_cnt_reg;
  logic [GW-1:0]         gap_cnt_reg;
  logic                  ready_en_reg;
  logic                  out_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  ready_state;
  logic                  accept;
`ifdef TRANSMITTER_PARITY_EN
  logic                  parity_reg;
`endif

  // Keeps in_ready low until the first clock edge after reset is released.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
    end
  end

  // States in which a new word may be taken; STOP only when frames may abut.
  always_comb begin
    ready_state = 1'b0;
    case (state_reg)
      S_IDLE:  ready_state = 1'b1;
      S_STOP:  ready_state = (GAP_CYCLES == 0);
      default: ready_state = 1'b0;
    endcase
  end

  assign in_ready = ready_en_reg & ready_state;
  assign accept   = in_valid & in_ready;
  assign out      = out_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

  // Frame sequencer: line, busy and done are registered alongside the state.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_reg   <= S_IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      out_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
`ifdef TRANSMITTER_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            state_reg  <= S_START;
            shift_reg  <= in_data;
            out_reg    <= 1'b1;
            busy_reg   <= 1'b1;
`ifdef TRANSMITTER_PARITY_EN
            parity_reg <= ^in_data;
`endif
          end
        end
        S_START: begin
          // First data bit goes out now; the register then holds bit 1 onward.
          state_reg   <= S_DATA;
          out_reg     <= shift_reg[0];
          shift_reg   <= shift_reg >> 1;
          bit_cnt_reg <= '0;
        end
        S_DATA: begin
          if (bit_cnt_reg == BIT_LAST) begin
`ifdef TRANSMITTER_PARITY_EN
            state_reg <= S_PARITY;
            out_reg   <= parity_reg;
`else
            state_reg <= S_STOP;
            out_reg   <= 1'b1;
            done_reg  <= 1'b1;
`endif
          end else begin
            out_reg     <= shift_reg[0];
            shift_reg   <= shift_reg >> 1;
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end
`ifdef TRANSMITTER_PARITY_EN
        S_PARITY: begin
          state_reg <= S_STOP;
          out_reg   <= 1'b1;
          done_reg  <= 1'b1;
        end
`endif
        S_STOP: begin
          if (accept) begin
            // Back-to-back: start bit directly follows the stop bit.
            state_reg  <= S_START;
            shift_reg  <= in_data;
            out_reg    <= 1'b1;
            busy_reg   <= 1'b1;
`ifdef TRANSMITTER_PARITY_EN
            parity_reg <= ^in_data;
`endif
          end else if (GAP_CYCLES > 0) begin
            state_reg   <= S_GAP;
            gap_cnt_reg <= '0;
            out_reg     <= 1'b0;
            busy_reg    <= 1'b1;
          end else begin
            state_reg <= S_IDLE;
            out_reg   <= 1'b0;
            busy_reg  <= 1'b0;
          end
        end
        S_GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
          out_reg <= 1'b0;
        end
        default: begin
          state_reg <= S_IDLE;
          out_reg   <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule
